// File: rtl/verificador_tiro.sv
// Purpose : battleship shot resolver; walks one player's ship bitmaps and reports invalid/repeat/miss/hit/sunk/game-over.
// Latency : invalid/repeat ready 2 cycles after accept, hit on ship k 4+2k cycles, miss 2+2*NUM_NAVIOS cycles.
// Backpressure: requester holds enable until ready; results hold in FIM while enable stays high and until the next accepted request.
module verificador_tiro #(
  parameter int NUM_NAVIOS = 11,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              jogador,
  input  logic [3:0]        x,
  input  logic [3:0]        y,
  input  logic [63:0]       vetor_leitura,
  output logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              acerto,
  output logic              afundou,
  output logic              repetido,
  output logic              invalido,
  output logic [3:0]        navio,
  output logic [2:0]        tipo_navio,
  output logic              fim_jogo
);

  // Ship count as a counter value and the address of the last stored ship.
  localparam logic [3:0]        LP_NUM  = 4'(NUM_NAVIOS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_NAVIOS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERIFICA,
    ST_ESPERA,
    ST_AVALIA,
    ST_FIM
  } state_t;

  state_t              r_state;

  // Latched request.
  logic                r_jog;
  logic [3:0]          r_x;
  logic [3:0]          r_y;

  // Registered outputs.
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ready;
  logic                r_acerto;
  logic                r_afundou;
  logic                r_repetido;
  logic                r_invalido;
  logic [3:0]          r_navio;
  logic [2:0]          r_tipo;
  logic                r_fim;

  // Per-board history: one bit per cell already shot, and ships sunk so far.
  logic [1:0][63:0]    r_mask;
  logic [1:0][3:0]     r_cnt;

  logic [5:0]          w_idx;
  logic [63:0]         w_onehot;
  logic [63:0]         w_mask_cur;
  logic [3:0]          w_cnt_cur;
  logic [3:0]          w_cnt_inc;
  logic                w_fora;
  logic                w_hit;
  logic                w_sunk;
  logic                w_last;

  // Ship type from its storage slot: slots are grouped by class.
  function automatic logic [2:0] f_tipo(input logic [ADDR_W-1:0] a);
    logic [2:0] t;
    if (a <= ADDR_W'(4))      t = 3'b000;
    else if (a <= ADDR_W'(6)) t = 3'b001;
    else if (a <= ADDR_W'(8)) t = 3'b010;
    else if (a == ADDR_W'(9)) t = 3'b011;
    else                      t = 3'b100;
    return t;
  endfunction

  // Cell index is y*8+x; only meaningful once the coordinate is known to be in range.
  assign w_idx      = {r_y[2:0], r_x[2:0]};
  assign w_onehot   = 64'd1 << w_idx;
  assign w_mask_cur = r_mask[r_jog];
  assign w_cnt_cur  = r_cnt[r_jog];
  assign w_cnt_inc  = (w_cnt_cur >= LP_NUM) ? LP_NUM : (w_cnt_cur + 4'd1);
  assign w_fora     = r_x[3] | r_y[3];
  assign w_hit      = vetor_leitura[w_idx];
  // The ship sinks when every one of its cells is either this shot or an earlier one.
  assign w_sunk     = ((vetor_leitura & ~(w_mask_cur | w_onehot)) == 64'd0);
  assign w_last     = (r_addr == LP_LAST);

  // Shot resolution FSM; all results are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_jog      <= 1'b0;
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_addr     <= '0;
      r_ready    <= 1'b0;
      r_acerto   <= 1'b0;
      r_afundou  <= 1'b0;
      r_repetido <= 1'b0;
      r_invalido <= 1'b0;
      r_navio    <= 4'd0;
      r_tipo     <= 3'd0;
      r_fim      <= 1'b0;
      r_mask     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          if (enable) begin
            r_jog      <= jogador;
            r_x        <= x;
            r_y        <= y;
            r_acerto   <= 1'b0;
            r_afundou  <= 1'b0;
            r_repetido <= 1'b0;
            r_invalido <= 1'b0;
            r_navio    <= 4'd0;
            r_tipo     <= 3'd0;
            r_fim      <= 1'b0;
            r_state    <= ST_VERIFICA;
          end
        end

        ST_VERIFICA: begin
          if (w_fora) begin
            r_invalido <= 1'b1;
            r_fim      <= (w_cnt_cur == LP_NUM);
            r_state    <= ST_FIM;
          end else if (w_mask_cur[w_idx]) begin
            r_repetido <= 1'b1;
            r_fim      <= (w_cnt_cur == LP_NUM);
            r_state    <= ST_FIM;
          end else begin
            r_addr  <= '0;
            r_state <= ST_ESPERA;
          end
        end

        // Memory returns the bitmap one cycle after the address changes.
        ST_ESPERA: begin
          r_state <= ST_AVALIA;
        end

        ST_AVALIA: begin
          if (w_hit) begin
            r_acerto             <= 1'b1;
            r_navio              <= 4'(r_addr);
            r_tipo               <= f_tipo(r_addr);
            r_mask[r_jog][w_idx] <= 1'b1;
            r_afundou            <= w_sunk;
            if (w_sunk) begin
              r_cnt[r_jog] <= w_cnt_inc;
              r_fim        <= (w_cnt_inc == LP_NUM);
            end else begin
              r_fim        <= (w_cnt_cur == LP_NUM);
            end
            r_state <= ST_FIM;
          end else if (w_last) begin
            // Misses are remembered so that a second identical shot reports repeat.
            r_mask[r_jog][w_idx] <= 1'b1;
            r_fim                <= (w_cnt_cur == LP_NUM);
            r_state              <= ST_FIM;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= ST_ESPERA;
          end
        end

        ST_FIM: begin
          r_ready <= 1'b1;
          if (!enable) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr       = r_addr;
  assign ready      = r_ready;
  assign acerto     = r_acerto;
  assign afundou    = r_afundou;
  assign repetido   = r_repetido;
  assign invalido   = r_invalido;
  assign navio      = r_navio;
  assign tipo_navio = r_tipo;
  assign fim_jogo   = r_fim;

endmodule

// File: tb/tb_verificador_tiro.sv
// Bench for the shot resolver: memory model with one-cycle read latency, board-level game model.
// Latency is measured from the accepting edge to the first edge after which ready is high.
// Requests hold enable until ready, then drop it.
module tb_verificador_tiro;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        jogador;
  logic [3:0]  x;
  logic [3:0]  y;
  logic [63:0] vetor_leitura;
  logic [4:0]  addr;
  logic        ready;
  logic        acerto;
  logic        afundou;
  logic        repetido;
  logic        invalido;
  logic [3:0]  navio;
  logic [2:0]  tipo_navio;
  logic        fim_jogo;

  int n_checks = 0;
  int n_errors = 0;
  int shot_id  = 0;

  // Boards as stored in memory, plus the game state the bench expects.
  logic [63:0] mem [2][N];
  logic [63:0] m_shot [2];
  int          m_sunk [2];
  int          m_addr;
  int          q_x[$];
  int          q_y[$];
  int          tipo_tab [N] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 4};

  verificador_tiro #(.NUM_NAVIOS(N), .ADDR_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .jogador       (jogador),
    .x             (x),
    .y             (y),
    .vetor_leitura (vetor_leitura),
    .addr          (addr),
    .ready         (ready),
    .acerto        (acerto),
    .afundou       (afundou),
    .repetido      (repetido),
    .invalido      (invalido),
    .navio         (navio),
    .tipo_navio    (tipo_navio),
    .fim_jogo      (fim_jogo)
  );

  always #5 clk = ~clk;

  // Memory: data for the address presented at an edge appears after that edge.
  always @(posedge clk) begin
    if (int'(addr) < N) vetor_leitura <= mem[jogador][int'(addr)];
    else                vetor_leitura <= 64'd0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (shot %0d) got=%0h exp=%0h", tag, shot_id, got, exp);
    end
  endtask

  task automatic place(input int j, input int k, input int x0, input int yy, input int len);
    for (int i = 0; i < len; i++) begin
      mem[j][k][yy*8 + x0 + i] = 1'b1;
      if (j == 0) begin
        q_x.push_back(x0 + i);
        q_y.push_back(yy);
      end
    end
  endtask

  task automatic model_clear();
    m_shot[0] = 64'd0;
    m_shot[1] = 64'd0;
    m_sunk[0] = 0;
    m_sunk[1] = 0;
    m_addr    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One complete shot: predict from the game rules, run it, compare everything.
  task automatic shot(input int j, input int xx, input int yy);
    int lat, n, k, idx;
    bit got_rdy;
    logic e_inv, e_rep, e_hit, e_sunk, e_fim;
    int e_navio, e_tipo;
    shot_id++;
    e_inv = 0; e_rep = 0; e_hit = 0; e_sunk = 0; e_navio = 0; e_tipo = 0;
    idx = yy*8 + xx;
    k = -1;
    if (xx > 7 || yy > 7) begin
      e_inv = 1;
      lat   = 2;
    end else if (m_shot[j][idx]) begin
      e_rep = 1;
      lat   = 2;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (mem[j][s][idx]) begin
          k = s;
          break;
        end
      end
      m_shot[j][idx] = 1'b1;
      if (k >= 0) begin
        e_hit   = 1;
        e_navio = k;
        e_tipo  = tipo_tab[k];
        lat     = 4 + 2*k;
        m_addr  = k;
        e_sunk  = ((mem[j][k] & m_shot[j]) == mem[j][k]);
        if (e_sunk && m_sunk[j] < N) m_sunk[j]++;
      end else begin
        lat    = 2 + 2*N;
        m_addr = N - 1;
      end
    end
    e_fim = (m_sunk[j] == N);

    @(negedge clk);
    enable  = 1'b1;
    jogador = j[0];
    x       = xx[3:0];
    y       = yy[3:0];
    @(posedge clk);
    n = 0;
    got_rdy = 0;
    while (n < 60 && !got_rdy) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) got_rdy = 1;
    end
    check_eq("latency",  n,          lat);
    check_eq("invalido", invalido,   e_inv);
    check_eq("repetido", repetido,   e_rep);
    check_eq("acerto",   acerto,     e_hit);
    check_eq("afundou",  afundou,    e_sunk);
    check_eq("navio",    navio,      e_navio);
    check_eq("tipo",     tipo_navio, e_tipo);
    check_eq("fim_jogo", fim_jogo,   e_fim);
    check_eq("addr",     addr,       m_addr);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ready_low", ready, 1'b0);
  endtask

  initial begin
    int free_idx;
    reset   = 1'b1;
    enable  = 1'b0;
    jogador = 1'b0;
    x       = 4'd0;
    y       = 4'd0;
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) mem[j][k] = 64'd0;

    // Player one: full fleet, no overlaps.
    place(0, 0, 0, 0, 1);
    place(0, 1, 2, 0, 1);
    place(0, 2, 4, 0, 1);
    place(0, 3, 5, 2, 1);
    place(0, 4, 6, 0, 1);
    place(0, 5, 0, 2, 2);
    place(0, 6, 0, 4, 2);
    place(0, 7, 3, 4, 3);
    place(0, 8, 0, 6, 3);
    place(0, 9, 4, 6, 4);
    place(0, 10, 0, 7, 5);
    // Player two: carrier on row 0 plus one submarine.
    place(1, 10, 0, 0, 5);
    place(1, 0, 7, 7, 1);

    do_reset();
    #1;
    check_eq("rst_ready", ready, 1'b0);
    check_eq("rst_addr", addr, 5'd0);
    check_eq("rst_flags", {acerto, afundou, repetido, invalido, fim_jogo}, 5'd0);
    check_eq("rst_navio", {navio, tipo_navio}, 7'd0);

    shot(0, 9, 2);                 // out of range
    shot(0, 5, 2);                 // submarine at slot 3
    shot(0, 5, 2);                 // repeat
    for (int i = 0; i < 5; i++) shot(1, i, 0);   // carrier on player two
    shot(0, 0, 0);                 // player one unaffected by those
    shot(0, 7, 7);                 // empty cell: full walk
    shot(0, 7, 7);                 // repeat of a miss
    shot(1, 2, 9);                 // invalid on the other board

    for (int i = 0; i < 40; i++)
      shot($urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 9));

    // Sink the whole fleet of player one; the last sinking shot ends the game.
    for (int i = 0; i < q_x.size(); i++) shot(0, q_x[i], q_y[i]);
    shot(0, 8, 0);                 // invalid after game over still reports it
    shot(0, 0, 0);                 // repeat after game over
    shot(1, 7, 7);                 // other board is not over

    // Reset while the resolver is waiting on memory.
    free_idx = -1;
    for (int i = 0; i < 64; i++)
      if (free_idx < 0 && !m_shot[0][i]) free_idx = i;
    if (free_idx < 0) free_idx = 63;
    @(negedge clk);
    enable  = 1'b1;
    jogador = 1'b0;
    x       = 4'(free_idx % 8);
    y       = 4'(free_idx / 8);
    @(posedge clk);                // accepted
    @(posedge clk);                // now waiting on memory
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_ready", ready, 1'b0);
    check_eq("midrst_addr", addr, 5'd0);
    check_eq("midrst_flags", {acerto, afundou, repetido, invalido, fim_jogo}, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    shot(0, 5, 2);                 // previously hit, history now cleared
    shot(0, 0, 7);
    for (int i = 0; i < 15; i++)
      shot($urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 9));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
